// File: rtl/co_fetch_pkg.sv
// co_fetch_pkg: shared constants, buffer entry type and RVC sizing helper for the fetch sequencer
package co_fetch_pkg;
   localparam logic [1:0]  RVC_FULL  = 2'b11;
   localparam logic [31:0] PC_STEP_C = 32'd2;
   localparam logic [31:0] PC_STEP_I = 32'd4;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
      logic        is_c;
   } entry_t;
   localparam int ENTRY_W = $bits(entry_t);
   function automatic logic is_rvc(input logic [15:0] lo_hw);
      return lo_hw[1:0] != RVC_FULL;
   endfunction
endpackage

// File: rtl/co_fetch_seq_if.sv
// co_fetch_seq_if: redirect, decoder-side and instruction-memory signals of the fetch sequencer
interface co_fetch_seq_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
   logic        instr_is_c;
   logic [31:0] mem_addrpred1;
   logic [31:0] mem_addrpred2;
   logic        mem_renablepred;
   logic [15:0] mem_rdata_pred1;
   logic [15:0] mem_rdata_pred2;
   modport master (
      output redirect_valid, redirect_pc, instr_ready, mem_rdata_pred1, mem_rdata_pred2,
      input  instr_valid, instr_data, instr_pc, instr_is_c, mem_addrpred1, mem_addrpred2, mem_renablepred
   );
   modport slave (
      input  redirect_valid, redirect_pc, instr_ready, mem_rdata_pred1, mem_rdata_pred2,
      output instr_valid, instr_data, instr_pc, instr_is_c, mem_addrpred1, mem_addrpred2, mem_renablepred
   );
endinterface

// File: rtl/co_fetch_fifo.sv
// co_fetch_fifo: small synchronous instruction buffer with flush; head read straight from storage
module co_fetch_fifo
   import co_fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  entry_t        din_i,
   output entry_t        head_o,
   output logic [AW:0]   count_o
);
   entry_t        mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   count_q;
   assign head_o  = mem_q[rd_q];
   assign count_o = count_q;
   // pointers wrap naturally because DEPTH is a power of two; flush only resets the pointers
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (flush_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_q] <= din_i;
            wr_q        <= wr_q + AW'(1);
         end
         if (pop_i) rd_q <= rd_q + AW'(1);
         count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
      end
endmodule

// File: rtl/co_fetch_seq.sv
// co_fetch_seq: issues dual-halfword fetches, sizes returned instructions and buffers them for decode
module co_fetch_seq
   import co_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input logic           clk,
   input logic           rst,
   co_fetch_seq_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   logic          req_vld_q, req_vld_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   resp_next;
   logic          resp_c, push, pop, issue;
   logic [AW+1:0] credit;
   logic [AW:0]   occ;
   entry_t        resp, head;
   // pc_q is both the pc of the in-flight request and the hold pc: both load issue_pc every cycle
   always_comb begin
      resp_c    = is_rvc(bus.mem_rdata_pred1);
      resp      = '{pc: pc_q, data: resp_c ? {16'h0, bus.mem_rdata_pred1} : {bus.mem_rdata_pred2, bus.mem_rdata_pred1}, is_c: resp_c};
      resp_next = pc_q + (resp_c ? PC_STEP_C : PC_STEP_I);
      push      = req_vld_q && !bus.redirect_valid;
      pop       = (occ != '0) && !bus.redirect_valid && bus.instr_ready;
      pc_d      = bus.redirect_valid ? {bus.redirect_pc[31:1], 1'b0} : req_vld_q ? resp_next : pc_q;
      credit    = (AW+2)'(occ) + (AW+2)'(push) - (AW+2)'(pop);
      issue     = !rst && (bus.redirect_valid || credit < (AW+2)'(FIFO_DEPTH));
      req_vld_d = issue;
   end
   // request/pc registers; a read is only issued when its response is guaranteed a buffer slot
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         req_vld_q <= 1'b0;
         pc_q      <= RESET_PC;
      end else begin
         req_vld_q <= req_vld_d;
         pc_q      <= pc_d;
      end
   co_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (bus.redirect_valid),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (resp),
      .head_o  (head),
      .count_o (occ)
   );
   assign bus.instr_valid     = (occ != '0) && !bus.redirect_valid;
   assign bus.instr_data      = head.data;
   assign bus.instr_pc        = head.pc;
   assign bus.instr_is_c      = head.is_c;
   assign bus.mem_addrpred1   = pc_d;
   assign bus.mem_addrpred2   = pc_d + PC_STEP_C;
   assign bus.mem_renablepred = issue;
   a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
      !(push && occ == (AW+1)'(FIFO_DEPTH)));
endmodule

// File: tb/tb_co_fetch_seq.sv
// tb_co_fetch_seq: directed and randomized checks of the fetch sequencer against an instruction-stream model
module tb_co_fetch_seq;
   localparam int DEPTH = 2;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          vectors = 0;
   int          miscompares = 0;
   int          pops = 0;
   int          p0;
   logic [31:0] exp_pc = 32'h0;
   logic [31:0] p;
   co_fetch_seq_if bus ();
   co_fetch_seq #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
   always #5 clk = ~clk;
   function automatic logic [15:0] hw(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 16'h4505;
         32'h0000_0002: return 16'h0093;
         32'h0000_0004: return 16'h0010;
         32'h0000_0006: return 16'h8082;
         32'hFFFF_FFFE: return 16'h1117;
         default:       return (a[16:1] * 16'hA5B3) ^ a[31:16] ^ 16'h3C6B;
      endcase
   endfunction
   // {is_c, data} of the instruction starting at byte address pc
   function automatic logic [32:0] instr_at(input logic [31:0] pc);
      logic [15:0] lo, hi;
      lo = hw(pc);
      hi = hw(pc + 32'd2);
      return (lo[1:0] != 2'b11) ? {1'b1, 16'h0, lo} : {1'b0, hi, lo};
   endfunction
   function automatic logic [31:0] nxt(input logic [31:0] pc);
      logic [32:0] e;
      e = instr_at(pc);
      return pc + (e[32] ? 32'd2 : 32'd4);
   endfunction
   always @(posedge clk)
      if (bus.mem_renablepred) begin
         bus.mem_rdata_pred1 <= hw(bus.mem_addrpred1);
         bus.mem_rdata_pred2 <= hw(bus.mem_addrpred2);
      end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic sb();
      logic [32:0] e;
      if (bus.redirect_valid) begin
         chk("valid_in_redirect", 32'(bus.instr_valid), 32'h0);
         exp_pc = {bus.redirect_pc[31:1], 1'b0};
      end else if (bus.instr_valid && bus.instr_ready) begin
         e = instr_at(exp_pc);
         chk("stream_pc", bus.instr_pc, exp_pc);
         chk("stream_data", bus.instr_data, e[31:0]);
         chk("stream_is_c", 32'(bus.instr_is_c), 32'(e[32]));
         exp_pc = nxt(exp_pc);
         pops++;
      end
   endtask
   task automatic mid();
      @(negedge clk);
   endtask
   task automatic fin();
      sb();
      @(posedge clk);
      #1;
   endtask
   task automatic cyc();
      mid();
      fin();
   endtask
   initial begin
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.instr_ready    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      mid();
      chk("rst_valid", 32'(bus.instr_valid), 32'h0);
      chk("rst_data", bus.instr_data, 32'h0);
      chk("rst_pc", bus.instr_pc, 32'h0);
      chk("rst_is_c", 32'(bus.instr_is_c), 32'h0);
      chk("rst_ren", 32'(bus.mem_renablepred), 32'h0);
      fin();
      rst = 1'b0;
      mid();
      chk("t1_addr1_a", bus.mem_addrpred1, 32'h0);
      chk("t1_addr2_a", bus.mem_addrpred2, 32'h2);
      chk("t1_ren_a", 32'(bus.mem_renablepred), 32'h1);
      chk("t1_valid_a", 32'(bus.instr_valid), 32'h0);
      fin();
      mid();
      chk("t1_addr1_b", bus.mem_addrpred1, 32'h2);
      chk("t1_addr2_b", bus.mem_addrpred2, 32'h4);
      fin();
      mid();
      chk("t1_addr1_c", bus.mem_addrpred1, 32'h6);
      chk("t1_addr2_c", bus.mem_addrpred2, 32'h8);
      chk("t1_valid_c", 32'(bus.instr_valid), 32'h1);
      chk("t1_pc0", bus.instr_pc, 32'h0);
      chk("t1_data0", bus.instr_data, 32'h0000_4505);
      fin();
      mid();
      chk("t1_pc2", bus.instr_pc, 32'h2);
      chk("t1_data2", bus.instr_data, 32'h0010_0093);
      fin();
      mid();
      chk("t1_pc6", bus.instr_pc, 32'h6);
      chk("t1_data6", bus.instr_data, 32'h0000_8082);
      fin();
      bus.instr_ready = 1'b0;
      repeat (10) cyc();
      mid();
      p = exp_pc;
      repeat (DEPTH) p = nxt(p);
      chk("t2_valid", 32'(bus.instr_valid), 32'h1);
      chk("t2_ren", 32'(bus.mem_renablepred), 32'h0);
      chk("t2_head", bus.instr_pc, exp_pc);
      chk("t2_hold", bus.mem_addrpred1, p);
      fin();
      bus.instr_ready = 1'b1;
      repeat (20) cyc();
      bus.instr_ready = 1'b0;
      cyc();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h7;
      bus.instr_ready    = 1'b1;
      mid();
      chk("t3_addr1", bus.mem_addrpred1, 32'h6);
      chk("t3_addr2", bus.mem_addrpred2, 32'h8);
      chk("t3_ren", 32'(bus.mem_renablepred), 32'h1);
      fin();
      bus.redirect_valid = 1'b0;
      mid();
      chk("t3_valid_t1", 32'(bus.instr_valid), 32'h0);
      fin();
      mid();
      chk("t3_valid_t2", 32'(bus.instr_valid), 32'h1);
      chk("t3_pc", bus.instr_pc, 32'h6);
      chk("t3_data", bus.instr_data, 32'h0000_8082);
      fin();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0;
      cyc();
      bus.redirect_pc = 32'h4;
      cyc();
      bus.redirect_valid = 1'b0;
      mid();
      chk("t4_valid_t1", 32'(bus.instr_valid), 32'h0);
      fin();
      mid();
      chk("t4_valid_t2", 32'(bus.instr_valid), 32'h1);
      chk("t4_pc", bus.instr_pc, 32'h4);
      fin();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFFE;
      mid();
      chk("t5_addr1", bus.mem_addrpred1, 32'hFFFF_FFFE);
      chk("t5_addr2", bus.mem_addrpred2, 32'h0);
      fin();
      bus.redirect_valid = 1'b0;
      mid();
      chk("t5_next_issue", bus.mem_addrpred1, 32'h2);
      fin();
      mid();
      chk("t5_pc", bus.instr_pc, 32'hFFFF_FFFE);
      chk("t5_data", bus.instr_data, 32'h4505_1117);
      fin();
      p0 = pops;
      repeat (400) begin
         bus.instr_ready    = ($urandom_range(3) != 0);
         bus.redirect_valid = ($urandom_range(15) == 0);
         bus.redirect_pc    = ($urandom_range(1) != 0) ? $urandom : 32'($urandom_range(15));
         cyc();
      end
      chk("rand_progress", 32'(pops - p0 > 100), 32'h1);
      bus.instr_ready    = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h100;
      cyc();
      bus.redirect_valid = 1'b0;
      repeat (6) cyc();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("t6_valid", 32'(bus.instr_valid), 32'h0);
      chk("t6_data", bus.instr_data, 32'h0);
      chk("t6_pc", bus.instr_pc, 32'h0);
      chk("t6_is_c", 32'(bus.instr_is_c), 32'h0);
      chk("t6_ren", 32'(bus.mem_renablepred), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      exp_pc = 32'h0;
      p0     = pops;
      mid();
      chk("t6_addr1", bus.mem_addrpred1, 32'h0);
      chk("t6_ren_on", 32'(bus.mem_renablepred), 32'h1);
      fin();
      repeat (6) cyc();
      chk("t6_resume_pops", 32'(pops - p0), 32'd5);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
